// File: rtl/updown_mod_counter.sv
// Modulo-MODULUS up/down counter with saturating parallel load, count enable,
// combinational terminal count (for cascading) and a registered wrap pulse.
module updown_mod_counter #(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 10,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             tc,
  output logic             co
);

  // MODULUS may equal 2**WIDTH, so range checks on d need one extra bit
  localparam logic [WIDTH:0]   L_MOD   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] L_MAX   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] L_RESET = WIDTH'(RESET_VALUE);

  generate
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
      $error("updown_mod_counter: MODULUS out of range 2..2**WIDTH");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_bad_reset
      $error("updown_mod_counter: RESET_VALUE must be below MODULUS");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic             r_co;
  logic [WIDTH-1:0] w_nextQ;
  logic             w_nextCo;
  logic             w_atTop;
  logic             w_atBottom;
  logic             w_dInRange;
  logic             w_wrap;

  assign w_atTop    = (r_q == L_MAX);
  assign w_atBottom = (r_q == '0);
  assign w_dInRange = ({1'b0, d} < L_MOD);
  assign w_wrap     = up ? w_atTop : w_atBottom;

  // Load wins over counting; wrapping steps modulo MODULUS, not 2**WIDTH
  always_comb begin
    w_nextQ  = r_q;
    w_nextCo = 1'b0;
    if (load) begin
      w_nextQ = w_dInRange ? d : L_MAX;
    end else if (en) begin
      w_nextCo = w_wrap;
      if (up) begin
        w_nextQ = w_atTop ? '0 : r_q + WIDTH'(1);
      end else begin
        w_nextQ = w_atBottom ? L_MAX : r_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q  <= L_RESET;
      r_co <= 1'b0;
    end else begin
      r_q  <= w_nextQ;
      r_co <= w_nextCo;
    end
  end

  assign q   = r_q;
  assign q_n = ~r_q;
  assign co  = r_co;
  // Valid in the same cycle as the wrap edge so the next stage steps with it
  assign tc  = en & ~load & w_wrap;

endmodule
